// File: rtl/mlp_mac_pkg.sv
// Shared constants and types for the MLP multiply-accumulate lane.
package mlp_mac_pkg;

    localparam int DEF_A_W        = 18;
    localparam int DEF_B_W        = 18;
    localparam int DEF_ACC_W      = 40;
    localparam int DEF_OUT_W      = 18;
    localparam int DEF_FRAC_SHIFT = 13;

    // Smallest accumulator that holds one full-precision product.
    function automatic int min_acc_w(input int aw, input int bw);
        return aw + bw;
    endfunction

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_t;

endpackage

// File: rtl/mlp_mac_narrow.sv
// Round-half-up, arithmetic shift and narrowing of the accumulator.
// MLP_MAC_SAT_EN selects saturating narrowing with ovf; otherwise wrap with ovf=0.
module mlp_mac_narrow #(
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 18,
    parameter int FRAC_SHIFT = 13
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf
);

    localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND =
        (FRAC_SHIFT > 0) ? ((ACC_W+1)'(1) <<< RND_SH) : '0;

    // One guard bit so adding the rounding constant cannot wrap.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] t;
        t = (ACC_W+1)'(v) + RND;
        return t >>> FRAC_SHIFT;
    endfunction

`ifdef MLP_MAC_SAT_EN
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] v);
        if (v > MAXV)
            return MAXV[OUT_W-1:0];
        else if (v < MINV)
            return MINV[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    logic signed [ACC_W:0] shifted;

    assign shifted = round_shift(acc);
    assign y       = saturate(shifted);
    assign ovf     = (shifted > MAXV) || (shifted < MINV);
`else
    assign y   = OUT_W'(round_shift(acc));
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mlp_mac_pipe.sv
// Pipelined signed MAC lane with first/last framing and rounded narrow output.
// Define MLP_MAC_SAT_EN for saturating narrowing (see mlp_mac_narrow).
module mlp_mac_pipe
    import mlp_mac_pkg::*;
#(
    parameter int A_W        = DEF_A_W,
    parameter int B_W        = DEF_B_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int MUL_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] acc_out,
    output logic signed [ACC_W-1:0] acc_full,
    output logic                    ovf
);

    localparam int PROD_W = min_acc_w(A_W, B_W);

    logic signed [A_W-1:0]    a_p0;
    logic signed [B_W-1:0]    b_p0;
    beat_t                    flg_p0;
    logic signed [PROD_W-1:0] prod_pm;
    beat_t                    flg_pm;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_pa;
    logic                     vld_pa;
    logic signed [ACC_W-1:0]  acc_pr;
    logic                     vld_pr;
    logic signed [OUT_W-1:0]  narrow_y;
    logic                     narrow_ovf;

    // Stage I: input registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_p0   <= '0;
            b_p0   <= '0;
            flg_p0 <= '0;
        end else if (ce) begin
            a_p0   <= a;
            b_p0   <= b;
            flg_p0 <= '{valid: in_valid, first: in_first, last: in_last};
        end
    end

    // Stages M1..Mn: product and its flags
    for (genvar i = 1; i <= MUL_STAGES; i++) begin : g_mul
        logic signed [PROD_W-1:0] prod;
        beat_t                    flg;
        if (i == 1) begin : g_first
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prod <= '0;
                    flg  <= '0;
                end else if (ce) begin
                    prod <= PROD_W'(a_p0) * PROD_W'(b_p0);
                    flg  <= flg_p0;
                end
            end
        end else begin : g_delay
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prod <= '0;
                    flg  <= '0;
                end else if (ce) begin
                    prod <= g_mul[i-1].prod;
                    flg  <= g_mul[i-1].flg;
                end
            end
        end
    end

    assign prod_pm  = g_mul[MUL_STAGES].prod;
    assign flg_pm   = g_mul[MUL_STAGES].flg;
    assign prod_ext = ACC_W'(prod_pm);

    // Stage A: accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_pa <= '0;
            vld_pa <= 1'b0;
        end else if (ce) begin
            if (flg_pm.valid)
                acc_pa <= flg_pm.first ? prod_ext : acc_pa + prod_ext;
            vld_pa <= flg_pm.valid & flg_pm.last;
        end
    end

    // Stage R: snapshot the finished sum so the rounding adder stays out of the accumulator loop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_pr <= '0;
            vld_pr <= 1'b0;
        end else if (ce) begin
            if (vld_pa)
                acc_pr <= acc_pa;
            vld_pr <= vld_pa;
        end
    end

    mlp_mac_narrow #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_narrow (
        .acc (acc_pr),
        .y   (narrow_y),
        .ovf (narrow_ovf)
    );

    // Stage O: outputs hold between results; out_valid is a one-ce-edge pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            acc_out   <= '0;
            acc_full  <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= vld_pr;
            if (vld_pr) begin
                acc_full <= acc_pr;
                acc_out  <= narrow_y;
                ovf      <= narrow_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mlp_mac_pipe.sv
// Scoreboard bench for mlp_mac_pipe: default lane plus a FRAC_SHIFT=0 lane.
module tb_mlp_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, ce, in_valid, in_first, in_last, use_fs0;
    logic signed [17:0] a, b;
    logic               iv0, iv1;
    logic               ov0, ov1, of0, of1;
    logic signed [17:0] ao0, ao1;
    logic signed [39:0] af0, af1;

    assign iv0 = in_valid & ~use_fs0;
    assign iv1 = in_valid & use_fs0;

    mlp_mac_pipe dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(iv0),
        .in_first(in_first), .in_last(in_last), .a(a), .b(b),
        .out_valid(ov0), .acc_out(ao0), .acc_full(af0), .ovf(of0)
    );

    mlp_mac_pipe #(.FRAC_SHIFT(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(iv1),
        .in_first(in_first), .in_last(in_last), .a(a), .b(b),
        .out_valid(ov1), .acc_out(ao1), .acc_full(af1), .ovf(of1)
    );

    typedef struct {
        int     at;
        longint full;
        longint outv;
        bit     ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   ce_e;

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    task automatic push(input bit lane, input int lat, input longint full,
                        input longint outv, input bit ov);
        exp_t e;
        e.at   = cyc + 1 + lat;
        e.full = full;
        e.outv = outv;
        e.ovf  = ov;
        if (lane) q1.push_back(e);
        else      q0.push_back(e);
    endtask

    task automatic beat(input bit v, input bit f, input bit l, input int av, input int bv);
        in_valid = v;
        in_first = f;
        in_last  = l;
        a        = 18'(av);
        b        = 18'(bv);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a new result is one seen after a ce=1 edge
    always @(posedge clk) begin
        cyc++;
        ce_e = ce;
        #1;
        if (reset_n && ce_e) begin
            if (ov0) begin
                if (q0.size() == 0) chk("lane0 unexpected out_valid", 1, 0);
                else begin
                    e0 = q0.pop_front();
                    chk("lane0 latency edge", cyc, e0.at);
                    chk("lane0 acc_full", af0, e0.full);
                    chk("lane0 acc_out", ao0, e0.outv);
                    chk("lane0 ovf", of0, e0.ovf);
                end
            end
            if (ov1) begin
                if (q1.size() == 0) chk("lane1 unexpected out_valid", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("lane1 latency edge", cyc, e1.at);
                    chk("lane1 acc_full", af1, e1.full);
                    chk("lane1 acc_out", ao1, e1.outv);
                    chk("lane1 ovf", of1, e1.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b1;
        use_fs0  = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", ov0, 0);
        chk("reset acc_out", ao0, 0);
        chk("reset acc_full", af0, 0);
        chk("reset ovf", of0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // single beat
        push(0, 5, 67108864, 8192, 0);
        beat(1, 1, 1, 8192, 8192);
        idle(7);

        // three-beat frame, then back-to-back single-beat rounding cases
        beat(1, 1, 0, 8192, 8192);
        beat(1, 0, 0, 16384, -4096);
        push(0, 5, 16777216, 2048, 0);
        beat(1, 0, 1, 4096, 4096);
        push(0, 5, 4096, 1, 0);
        beat(1, 1, 1, 1, 4096);
        push(0, 5, -4096, 0, 0);
        beat(1, 1, 1, -1, 4096);
        push(0, 5, -4097, -1, 0);
        beat(1, 1, 1, -1, 4097);
        idle(7);

        // most-negative squared
`ifdef MLP_MAC_SAT_EN
        push(0, 5, 64'sd17179869184, 131071, 1);
`else
        push(0, 5, 64'sd17179869184, 0, 0);
`endif
        beat(1, 1, 1, -131072, -131072);
        idle(7);

        // first without a preceding last discards the partial sum
        beat(1, 1, 0, 100, 100);
        push(0, 5, 16384, 2, 0);
        beat(1, 1, 1, 2, 8192);
        idle(7);

        // bubble inside frame, ce low 3 cycles mid-pipeline, then ce low with out_valid high
        beat(1, 1, 0, 8192, 8192);
        beat(0, 0, 0, 0, 0);
        push(0, 8, 83886080, 10240, 0);
        beat(1, 0, 1, 4096, 4096);
        idle(1);
        ce = 1'b0;
        idle(3);
        ce = 1'b1;
        idle(4);
        ce = 1'b0;
        idle(2);
        chk("ce low holds out_valid", ov0, 1);
        chk("ce low holds acc_full", af0, 83886080);
        ce = 1'b1;
        idle(1);
        chk("out_valid drops on ce edge", ov0, 0);
        idle(3);

        // FRAC_SHIFT=0 lane: a result, then async reset mid-frame
        use_fs0 = 1'b1;
        push(1, 5, 30, 30, 0);
        beat(1, 1, 1, 5, 6);
        idle(7);
        beat(1, 1, 0, 7, 7);
        beat(1, 0, 0, 1, 1);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async reset out_valid", ov1, 0);
        chk("async reset acc_out", ao1, 0);
        chk("async reset acc_full", af1, 0);
        chk("async reset ovf", of1, 0);
        chk("async reset lane0 acc_full", af0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(1, 5, 12, 12, 0);
        beat(1, 1, 1, 3, 4);
        idle(7);

        // after reset, a beat without first accumulates onto 0
        beat(1, 1, 0, 7, 7);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("second reset out_valid", ov1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        push(1, 5, 25, 25, 0);
        beat(1, 0, 1, 5, 5);
        idle(8);

        chk("results still pending", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mlp_mac_pipe.md
Name: mlp_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the MLP datapath.
- Generalises the fixed 18x18 two-register DSP multiplier in four ways:
  - configurable operand, accumulator and output widths
  - configurable multiplier pipeline depth
  - valid/first/last framing, so a whole neuron dot product is accumulated in place
  - rounded fixed-point output narrowing
- Sits between the weight/activation fetch logic and the activation-function stage; one instance per neuron lane.

Parameters:
- A_W, 18, signed width of operand a
- B_W, 18, signed width of operand b
- ACC_W, 40, accumulator width; must be >= A_W+B_W
- OUT_W, 18, signed width of the narrowed result
- FRAC_SHIFT, 13, arithmetic right shift applied to the accumulator before narrowing; 0 = no shift, no rounding
- MUL_STAGES, 2, product pipeline registers after the input registers; must be >= 1

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; when low, every register in the block holds
- in_valid  in  1  a/b/in_first/in_last are valid this cycle
- in_first  in  1  beat starts a new dot product
- in_last  in  1  beat ends the current dot product
- a  in  A_W  signed operand
- b  in  B_W  signed operand
- out_valid  out  1  acc_out/acc_full are valid
- acc_out  out  OUT_W  rounded, shifted, narrowed result
- acc_full  out  ACC_W  raw accumulator value for the completed dot product
- ovf  out  1  saturation occurred on this result (feature-dependent)

Behaviour:
- Reset (reset_n low, asynchronous): all pipeline data, valid/first/last flags and the accumulator go to 0. Outputs out_valid=0, acc_out=0, acc_full=0, ovf=0.
- Pipeline (advances only on edges where ce=1):
  - Stage I: register a, b, in_valid, in_first, in_last.
  - Stages M1..M(MUL_STAGES): signed product, A_W+B_W bits. Flags travel alongside the product.
  - Stage A: accumulator, updated only for a valid beat. If first, acc <= sign-extended product; otherwise acc <= acc + product. ACC_W two's-complement arithmetic, wraps silently.
  - Stage O: loads on a valid beat with last set. Sets out_valid=1 and acc_full=acc after the Stage A update. acc_out = narrow((acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT), i.e. round-half-up. When FRAC_SHIFT=0 the rounding constant is omitted.
  - On any other ce=1 edge, out_valid <= 0. acc_out, acc_full and ovf hold their last values.
- Latency: in_last sampled at edge 0 gives out_valid=1 after edge MUL_STAGES+3, counted in ce=1 edges. Default latency is 5.
- Throughput: one beat per ce=1 cycle. Back-to-back dot products need no bubble; the first of one frame may directly follow the last of the previous.
- Boundary cases:
  - in_valid=0 bubble: accumulator and Stage O unchanged.
  - first and last on the same beat: single-term result.
  - first arriving without a preceding last: the partial sum is discarded and no output is produced for it.
  - Beat without first after reset: accumulates onto 0.
  - ce low while out_valid=1: out_valid stays high until the next ce=1 edge.
  - reset_n asserted mid-frame: everything is cleared and the in-flight partial result is lost, with no out_valid.
- Narrowing without the feature: keep the low OUT_W bits (wrap); ovf is held at 0.

Optional Feature:
- Macro: MLP_MAC_SAT_EN
- Defined: narrowing saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. ovf is registered in Stage O and is 1 exactly when clamping occurred for that result.
- Undefined: wrap narrowing; ovf is constant 0. Port list is unchanged.

Decomposition:
- Package mlp_mac_pkg holds:
  - default width constants (A_W, B_W, ACC_W, OUT_W, FRAC_SHIFT)
  - a function computing the minimum legal ACC_W
  - the beat-flag struct {valid, first, last} carried down the pipeline
- One natural sub-module, mlp_mac_narrow: combinational round/shift/saturate-or-wrap, parametrised on ACC_W, OUT_W and FRAC_SHIFT. It owns the MLP_MAC_SAT_EN switch.
- The multiplier delay line is a generate loop inside mlp_mac_pipe.

Test Plan:
- Defaults, ce=1, single beat a=8192, b=8192, first=last=1 -> out_valid exactly 5 edges later, acc_out=8192, acc_full=67108864, ovf=0.
- Three-beat frame (8192,8192), (16384,-4096), (4096,4096) -> one out_valid pulse; acc_full=16777216, acc_out=2048.
- Rounding, single beats:
  - a=1, b=4096 -> acc_out=1
  - a=-1, b=4096 -> acc_out=0
  - a=-1, b=4097 -> acc_out=-1
- Overflow, single beat a=b=-131072:
  - with MLP_MAC_SAT_EN -> acc_out=131071, ovf=1
  - without -> acc_out=0, ovf=0
  - both cases: acc_full=17179869184
- ce held low for 3 cycles mid-pipeline, plus an in_valid=0 bubble inside a 2-beat frame -> out_valid 8 edges after the last beat; sum unaffected by the bubble; out_valid held high while ce is low.
- reset_n pulsed low asynchronously mid-frame, then a fresh first=last beat (3,4) with FRAC_SHIFT=0 -> all outputs 0 immediately on reset; next result acc_out=12; no output for the aborted frame.
